mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Sequences the single-port RAM between the instruction-fetch path and the data-memory path (MemRd/MemWr) of the single-cycle/multicycle datapath.
- Registered three-state FSM with data-over-instruction priority, a fetch anti-starvation counter, a RAM busy watchdog, and per-requester wait signals that stall the datapath until the RAM access completes.

Parameters:
- ADDR_W, 32, address and data width (word_t).
- MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending; the next grant is forced to fetch.
- TIMEOUT, 64, max consecutive BUSY cycles in one access before the watchdog fires.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- halt  in  1  datapath halted; blocks new fetch grants
- iREN  in  1  instruction fetch request
- iaddr  in  32  fetch address
- iload  out  32  fetched instruction
- iwait  out  1  fetch stall
- dREN  in  1  data read request (MemRd)
- dWEN  in  1  data write request (MemWr)
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data
- dwait  out  1  data stall
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- err  out  1  sticky error flag (RAM ERROR or watchdog)

Behaviour:
- Reset: on CLK edge with nRST=0 the following apply.
  - state=IDLE; streak=0; wdog=0; err=0.
  - All outputs 0, except iwait and dwait, which follow their request combinationally.
- States: IDLE, IFETCH, DACC.
- IDLE:
  - The RAM enables are 0.
  - Grant decision is registered; the grant takes effect in the next cycle.
  - If dREN|dWEN and not (iREN & !halt & streak==MAX_DSTREAK): go to DACC and increment streak (saturating) only when iREN & !halt.
  - Else if iREN & !halt: go to IFETCH and clear streak.
  - Else stay in IDLE.
- DACC:
  - ramaddr=daddr; ramstore=dstore; ramREN=dREN & !dWEN; ramWEN=dWEN. dWEN wins if both dREN and dWEN are set.
- IFETCH:
  - ramaddr=iaddr; ramREN=1; ramWEN=0; ramstore=0.
  - halt asserted during IFETCH does not abort the fetch.
- Completion: in DACC or IFETCH, when ramstate==ACCESS:
  - the corresponding wait=0 combinationally that cycle;
  - dload/iload=ramload combinationally that cycle;
  - next state=IDLE.
  - Minimum latency is request at cycle 0, grant cycle 1, wait drops at cycle 1 if the RAM answers ACCESS immediately.
- Stalls:
  - iwait=iREN unless completing a fetch.
  - dwait=(dREN|dWEN) unless completing a data access.
  - Outside completion cycles, iload and dload are 0.
- Withdrawal: if the granted request drops (dREN=dWEN=0 in DACC, or iREN=0 in IFETCH), RAM enables go 0 combinationally and the next state is IDLE. No err.
- ERROR: ramstate==ERROR in DACC or IFETCH sets err=1 and the next state is IDLE. The wait stays asserted and the requester retries through normal arbitration.
- Watchdog:
  - wdog increments each cycle in DACC or IFETCH with ramstate==BUSY, and clears otherwise.
  - When wdog reaches TIMEOUT-1 while BUSY: err=1, next state IDLE, wdog cleared.
- err is sticky; it is cleared only by reset.
- Reset mid-access: state returns to IDLE and the enables drop in the same cycle the edge samples nRST=0. No partial completion is reported.
- Simultaneous iREN & dREN with streak<MAX_DSTREAK: data is granted and the fetch waits.

Test Plan:
- Reset and idle: nRST=0 for 2 cycles, then iREN=1, iaddr=0x100, RAM returns ACCESS with ramload=0x8C220004.
  - Required: cycle 1 ramREN=1, ramaddr=0x100.
  - Required: iload=0x8C220004 and iwait=0 in the ACCESS cycle.
  - Required: IDLE next cycle.
- Priority: iREN=1 and dWEN=1 (daddr=0x200, dstore=0xDEADBEEF) together.
  - Required: DACC is granted first, with ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF.
  - Required: the fetch is granted after the store completes.
- Anti-starvation: dREN held high for 6 consecutive accesses with iREN high, MAX_DSTREAK=4.
  - Required: grants are D,D,D,D,I,D.
- Wait states and withdrawal:
  - RAM BUSY for 3 cycles then ACCESS: dwait=1 for 3 cycles, then 0.
  - Separately, dREN dropped during BUSY: ramREN=0 the same cycle, IDLE next, err=0.
- Errors: with TIMEOUT=8 and RAM stuck BUSY, err=1 after 8 BUSY cycles and the state returns to IDLE. Separately, ramstate=ERROR sets err=1 and err stays 1 until nRST=0.
- Halt and reset: halt=1 with iREN=1 means no IFETCH grant. Asserting nRST=0 during DACC BUSY gives ramREN=ramWEN=0 and err=0 on the next cycle.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// ============================================================================
// Module   : mem_arbiter_ctrl
// Purpose  : Single-port RAM arbiter between instruction fetch and data access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam int WDOG_W   = $clog2(TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IFETCH = 2'd1;
    localparam logic [1:0] ST_DACC   = 2'd2;

    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] next_streak;
    logic [WDOG_W-1:0]   wdog;
    logic [WDOG_W-1:0]   next_wdog;
    logic                set_err;

    logic d_req;
    logic fetch_ok;
    logic i_active;
    logic d_active;
    logic ram_busy;
    logic ram_done;
    logic ram_fault;
    logic i_done;
    logic d_done;

    assign d_req     = dREN | dWEN;
    assign fetch_ok  = iREN & ~halt;
    assign ram_busy  = (ramstate == RS_BUSY);
    assign ram_done  = (ramstate == RS_ACCESS);
    assign ram_fault = (ramstate == RS_ERROR);

    // An access is live only while its requester still asks; reset kills it at once.
    assign i_active = nRST & (state == ST_IFETCH) & iREN;
    assign d_active = nRST & (state == ST_DACC) & d_req;
    assign i_done   = i_active & ram_done;
    assign d_done   = d_active & ram_done;

    assign ramREN   = i_active | (d_active & dREN & ~dWEN);
    assign ramWEN   = d_active & dWEN;
    assign ramaddr  = i_active ? iaddr : (d_active ? daddr : '0);
    assign ramstore = d_active ? dstore : '0;

    assign iload = i_done ? ramload : '0;
    assign dload = d_done ? ramload : '0;
    assign iwait = iREN & ~i_done;
    assign dwait = d_req & ~d_done;

    always_comb begin
        next_state  = state;
        next_streak = streak;
        next_wdog   = '0;
        set_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_req && !(fetch_ok && streak == STREAK_MAX)) begin
                    next_state = ST_DACC;
                    if (fetch_ok && streak != STREAK_MAX) begin
                        next_streak = streak + STREAK_W'(1);
                    end
                end else if (fetch_ok) begin
                    next_state  = ST_IFETCH;
                    next_streak = '0;
                end
            end
            ST_IFETCH, ST_DACC: begin
                if (!(i_active || d_active)) begin
                    next_state = ST_IDLE;
                end else if (ram_done) begin
                    next_state = ST_IDLE;
                end else if (ram_fault) begin
                    next_state = ST_IDLE;
                    set_err    = 1'b1;
                end else if (ram_busy) begin
                    if (wdog == WDOG_LAST) begin
                        next_state = ST_IDLE;
                        set_err    = 1'b1;
                    end else begin
                        next_wdog = wdog + WDOG_W'(1);
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= ST_IDLE;
            streak <= '0;
            wdog   <= '0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
            wdog   <= next_wdog;
            err    <= err | set_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
// ============================================================================
// Module   : tb_mem_arbiter_ctrl
// Purpose  : Directed plus randomized self-checking bench for mem_arbiter_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter_ctrl;

    localparam int AW   = 32;
    localparam int MAXD = 4;
    localparam int TMO  = 8;

    logic          CLK = 1'b0;
    logic          nRST, halt, iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr, dstore, ramload;
    logic [1:0]    ramstate;
    logic [AW-1:0] iload, dload, ramaddr, ramstore;
    logic          iwait, dwait, ramREN, ramWEN, err;

    always #5 CLK = ~CLK;

    mem_arbiter_ctrl #(.ADDR_W(AW), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    // Reference model: who owns the RAM (0 nobody, 1 fetch, 2 data),
    // consecutive data grants with a fetch waiting, busy cycles so far, sticky error.
    int    m_own = 0, m_streak = 0, m_busy = 0;
    bit    m_err = 0;
    int    n_own = 0, n_streak = 0, n_busy = 0;
    bit    n_err = 0;
    bit    started = 0;
    string grants[$];

    always @(negedge CLK) begin : p_compare
        bit          act, fin, fetch_ok, dreq;
        logic [31:0] e_addr, e_store;
        dreq     = dREN | dWEN;
        fetch_ok = iREN && !halt;
        act      = nRST && ((m_own == 1 && iREN) || (m_own == 2 && dreq));
        fin      = act && (ramstate == 2'd2);
        if (started) begin
            chk("ramREN", ramREN, act && (m_own == 1 || (dREN && !dWEN)));
            chk("ramWEN", ramWEN, act && m_own == 2 && dWEN);
            if (act) begin
                e_addr  = (m_own == 1) ? iaddr : daddr;
                e_store = (m_own == 1) ? 32'h0 : dstore;
                chk("ramaddr", ramaddr, e_addr);
                chk("ramstore", ramstore, e_store);
            end
            chk("iload", iload, (fin && m_own == 1) ? ramload : 32'h0);
            chk("dload", dload, (fin && m_own == 2) ? ramload : 32'h0);
            chk("iwait", iwait, iREN && !(fin && m_own == 1));
            chk("dwait", dwait, dreq && !(fin && m_own == 2));
            chk("err", err, m_err);
        end
        n_own = m_own; n_streak = m_streak; n_busy = 0; n_err = m_err;
        if (!nRST) begin
            n_own = 0; n_streak = 0; n_err = 0;
        end else if (m_own == 0) begin
            if (dreq && !(fetch_ok && m_streak >= MAXD)) begin
                n_own = 2;
                if (fetch_ok) n_streak = (m_streak < MAXD) ? m_streak + 1 : MAXD;
                grants.push_back("D");
            end else if (fetch_ok) begin
                n_own = 1; n_streak = 0;
                grants.push_back("I");
            end
        end else if (!act) begin
            n_own = 0;
        end else begin
            case (ramstate)
                2'd2: n_own = 0;
                2'd3: begin n_own = 0; n_err = 1; end
                2'd1: begin
                    if (m_busy + 1 == TMO) begin n_own = 0; n_err = 1; end
                    else n_busy = m_busy + 1;
                end
                default: ;
            endcase
        end
    end

    always @(posedge CLK) begin
        m_own = n_own; m_streak = n_streak; m_busy = n_busy; m_err = n_err;
        if (!nRST) started = 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        iREN = 0; dREN = 0; dWEN = 0; halt = 0; ramstate = 2'd0;
        tick();
        tick();
    endtask

    initial begin
        string s, ms;
        int    mode;
        nRST = 0; halt = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        tick();
        tick();
        #2;
        chk("rst_err", err, 0);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_iwait", iwait, 0);

        // First fetch after reset
        nRST = 1; iREN = 1; iaddr = 32'h100;
        #1;
        chk("f0_iwait", iwait, 1);
        chk("f0_ramREN", ramREN, 0);
        tick();
        ramstate = 2'd2; ramload = 32'h8C220004;
        #2;
        chk("f1_ramREN", ramREN, 1);
        chk("f1_ramaddr", ramaddr, 32'h100);
        chk("f1_iload", iload, 32'h8C220004);
        chk("f1_iwait", iwait, 0);
        tick();
        ramstate = 2'd0;
        #2;
        chk("f2_idle_ramREN", ramREN, 0);
        chk("f2_iload", iload, 0);
        quiet();

        // Data beats fetch when both arrive together
        iREN = 1; iaddr = 32'h400; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        tick();
        ramstate = 2'd2;
        #2;
        chk("p_ramWEN", ramWEN, 1);
        chk("p_ramREN", ramREN, 0);
        chk("p_ramaddr", ramaddr, 32'h200);
        chk("p_ramstore", ramstore, 32'hDEADBEEF);
        chk("p_iwait", iwait, 1);
        chk("p_dwait", dwait, 0);
        tick();
        dWEN = 0; ramstate = 2'd0;
        #2;
        chk("p_idle_ramREN", ramREN, 0);
        tick();
        ramstate = 2'd2;
        #2;
        chk("p_fetch_ramREN", ramREN, 1);
        chk("p_fetch_addr", ramaddr, 32'h400);
        chk("p_fetch_iwait", iwait, 0);
        quiet();

        // Anti-starvation: six grants with both requesters holding
        iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h300; ramstate = 2'd2;
        grants.delete();
        s = "";
        for (int i = 0; i < 12; i++) begin
            #2;
            if (ramREN) s = {s, (ramaddr == 32'h300) ? "D" : "I"};
            tick();
        end
        chk_str("starve_dut", s, "DDDDID");
        ms = "";
        for (int i = 0; i < 6 && i < grants.size(); i++) ms = {ms, grants[i]};
        chk_str("starve_model", ms, "DDDDID");
        quiet();

        // Three busy cycles then completion
        dREN = 1; daddr = 32'h500; ramload = 32'h12345678; ramstate = 2'd1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("ws_dwait_busy", dwait, 1);
            chk("ws_ramREN", ramREN, 1);
            tick();
        end
        ramstate = 2'd2;
        #2;
        chk("ws_dwait_done", dwait, 0);
        chk("ws_dload", dload, 32'h12345678);
        quiet();

        // Withdrawal during busy
        dREN = 1; daddr = 32'h600; ramstate = 2'd1;
        tick();
        #2;
        chk("wd_ramREN_on", ramREN, 1);
        tick();
        dREN = 0;
        #2;
        chk("wd_ramREN_off", ramREN, 0);
        tick();
        dREN = 1;
        #2;
        chk("wd_idle_ramREN", ramREN, 0);
        chk("wd_err", err, 0);
        quiet();

        // Watchdog on a RAM stuck busy
        dREN = 1; daddr = 32'h640; ramstate = 2'd1;
        tick();
        for (int i = 0; i < TMO; i++) begin
            #2;
            chk("wdog_err_pre", err, 0);
            chk("wdog_ramREN", ramREN, 1);
            tick();
        end
        #2;
        chk("wdog_err_post", err, 1);
        chk("wdog_idle_ramREN", ramREN, 0);
        quiet();
        chk("wdog_err_sticky", err, 1);
        nRST = 0;
        tick();
        nRST = 1;
        #2;
        chk("wdog_err_cleared", err, 0);

        // RAM error response
        dREN = 1; ramstate = 2'd3;
        tick();
        #2;
        chk("e_err_pre", err, 0);
        chk("e_dwait", dwait, 1);
        tick();
        #2;
        chk("e_err_set", err, 1);
        chk("e_idle_ramREN", ramREN, 0);
        dREN = 0; ramstate = 2'd0;
        tick();
        tick();
        #2;
        chk("e_err_sticky", err, 1);
        nRST = 0;
        #1;
        chk("e_err_before_edge", err, 1);
        tick();
        nRST = 1;
        #2;
        chk("e_err_cleared", err, 0);
        quiet();

        // Halt blocks fetch grants
        halt = 1; iREN = 1; iaddr = 32'h800;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk("h_ramREN", ramREN, 0);
            chk("h_iwait", iwait, 1);
        end
        quiet();

        // Reset in the middle of a busy store
        dWEN = 1; daddr = 32'h700; dstore = 32'h0000A5A5; ramstate = 2'd1;
        tick();
        #2;
        chk("r_ramWEN_on", ramWEN, 1);
        nRST = 0;
        tick();
        #2;
        chk("r_ramWEN_off", ramWEN, 0);
        chk("r_ramREN_off", ramREN, 0);
        chk("r_err", err, 0);
        nRST = 1;
        quiet();

        // Randomized traffic checked every cycle by the model
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (c % 500 == 0) mode = $urandom_range(0, 2);
            tick();
            nRST  = ($urandom_range(0, 149) != 0);
            halt  = ($urandom_range(0, 9) == 0);
            iREN  = ($urandom_range(0, 9) < 6);
            dREN  = ($urandom_range(0, 9) < 4);
            dWEN  = ($urandom_range(0, 9) < 3);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 99);
            case (mode)
                0: ramstate = (r < 15) ? 2'd0 : (r < 55) ? 2'd1 : (r < 98) ? 2'd2 : 2'd3;
                1: ramstate = (r < 5) ? 2'd0 : (r < 92) ? 2'd1 : (r < 99) ? 2'd2 : 2'd3;
                default: ramstate = (r < 30) ? 2'd0 : (r < 50) ? 2'd1 : 2'd2;
            endcase
        end
        quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
